// File: rtl/aes128_decrypt_iterative.sv
// Iterative AES-128 inverse cipher. Key schedule is expanded forward into a round-key file, then one inverse round runs per clock.
// Optional feature macro AES_DEC_KEY_CACHE_EN: a repeated key reuses the stored schedule and skips expansion.
module aes128_decrypt_iterative (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  localparam int NK  = 4;
  localparam int NR  = 10;
  localparam int BLK = 128;

  // state   | meaning
  // S_IDLE  | ready for a new ciphertext/key
  // S_KEXP  | expanding rk[1..10]; last step also applies rk[10]
  // S_ROUND | one inverse round per clock, rcnt 9 down to 0
  // S_DONE  | plaintext presented, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'd2047 - {b, 3'b000};
    return SBOX[pos -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'd2047 - {b, 3'b000};
    return INV_SBOX[pos -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (only 09/0b/0d/0e are needed).
  function automatic logic [7:0] gmul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul_k(a0, 4'he) ^ gmul_k(a1, 4'hb) ^ gmul_k(a2, 4'hd) ^ gmul_k(a3, 4'h9),
            gmul_k(a0, 4'h9) ^ gmul_k(a1, 4'he) ^ gmul_k(a2, 4'hb) ^ gmul_k(a3, 4'hd),
            gmul_k(a0, 4'hd) ^ gmul_k(a1, 4'h9) ^ gmul_k(a2, 4'he) ^ gmul_k(a3, 4'hb),
            gmul_k(a0, 4'hb) ^ gmul_k(a1, 4'hd) ^ gmul_k(a2, 4'h9) ^ gmul_k(a3, 4'he)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BLK-1:0] key_expand(input logic [BLK-1:0] rk, input logic [7:0] rc);
    logic [31:0] w [NK];
    logic [31:0] t;
    for (int i = 0; i < NK; i++) w[i] = rk[BLK-1-32*i -: 32];
    t = {sbox(w[NK-1][23:16]), sbox(w[NK-1][15:8]), sbox(w[NK-1][7:0]), sbox(w[NK-1][31:24])}
        ^ {rc, 24'h000000};
    w[0] = w[0] ^ t;
    for (int i = 1; i < NK; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Byte i sits at row i%4, column i/4; the key is added before InvMixColumns.
  function automatic logic [BLK-1:0] inv_round(input logic [BLK-1:0] s, input logic [BLK-1:0] k,
                                               input logic last);
    logic [7:0]     b [16];
    logic [BLK-1:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[BLK-1-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[BLK-1-8*(4*c+w) -: 8] = inv_sbox(b[4*((c - w + 4) % 4) + w]) ^ k[BLK-1-8*(4*c+w) -: 8];
    if (!last)
      for (int c = 0; c < 4; c++) r[BLK-1-32*c -: 32] = inv_mix_col(r[BLK-1-32*c -: 32]);
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rcnt_q;
  logic [BLK-1:0] blk_q;
  logic [BLK-1:0] rk_q [NR+1];
  logic [BLK-1:0] plaintext_q;
  logic [BLK-1:0] kexp_out;
  logic [BLK-1:0] rnd_out;
  logic           accept;
  logic           cache_hit;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_vld_q;
  assign cache_hit = cache_vld_q && (cipher_key == rk_q[0]);
`else
  assign cache_hit = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign kexp_out  = key_expand(rk_q[rcnt_q - 4'd1], rcon(rcnt_q));
  assign rnd_out   = inv_round(blk_q, rk_q[rcnt_q], rcnt_q == 4'd0);
  assign plaintext = plaintext_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = cache_hit ? S_ROUND : S_KEXP;
      S_KEXP:  if (rcnt_q == 4'(NR)) state_d = S_ROUND;
      S_ROUND: if (rcnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= 4'd0;
      plaintext_q <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          if (cache_hit) begin
            blk_q  <= ciphertext ^ rk_q[NR];
            rcnt_q <= 4'(NR - 1);
          end else begin
            blk_q    <= ciphertext;
            rk_q[0]  <= cipher_key;
            rcnt_q   <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
          end
        end
        S_KEXP: begin
          rk_q[rcnt_q] <= kexp_out;
          if (rcnt_q == 4'(NR)) begin
            blk_q  <= blk_q ^ kexp_out;
            rcnt_q <= 4'(NR - 1);
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b1;
`endif
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        S_ROUND: begin
          blk_q <= rnd_out;
          if (rcnt_q == 4'd0) plaintext_q <= rnd_out;
          else                rcnt_q      <= rcnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iterative.sv
// Bench for aes128_decrypt_iterative: FIPS vectors plus random blocks encrypted by a forward AES model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes128_decrypt_iterative;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext = '0;
  logic [127:0] cipher_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] plaintext;

  int           n_chk = 0;
  int           n_bad = 0;
  logic [7:0]   sb [256];
  logic         cache_vld_m = 1'b0;
  logic [127:0] cache_key_m = '0;

  always #5 clk = ~clk;

  aes128_decrypt_iterative dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .cipher_key (cipher_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sb[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
    return (CACHE && cache_vld_m && key == cache_key_m) ? 10 : 20;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst plaintext", plaintext, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    cache_vld_m = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] pt, input int hold);
    int   lat;
    int   el;
    logic busy_rdy;
    logic stable;
    el = exp_lat(key);
    @(negedge clk);
    ciphertext = ct;
    cipher_key = key;
    in_valid   = 1'b1;
    out_ready  = (hold == 0);
    check({tag, " in_ready"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    lat = 0;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      busy_rdy = busy_rdy | in_ready;
      in_valid   = 1'($urandom_range(0, 1));
      ciphertext = rnd128();
      cipher_key = rnd128();
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, 128'(out_valid), 128'd1);
    check({tag, " latency"}, 128'(lat), 128'(el));
    check({tag, " busy in_ready"}, 128'(busy_rdy), 128'd0);
    check({tag, " plaintext"}, plaintext, pt);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      stable = stable & (plaintext == pt) & out_valid & ~in_ready;
    end
    check({tag, " hold stable"}, 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " drained out_valid"}, 128'(out_valid), 128'd0);
    check({tag, " drained in_ready"}, 128'(in_ready), 128'd1);
    cache_vld_m = 1'b1;
    cache_key_m = key;
  endtask

  task automatic run_abort(input logic [127:0] ct, input logic [127:0] key);
    logic quiet;
    @(negedge clk);
    ciphertext = ct;
    cipher_key = key;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort in_ready", 128'(in_ready), 128'd1);
    check("abort plaintext", plaintext, 128'd0);
    rst = 1'b0;
    cache_vld_m = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      quiet = quiet & ~out_valid;
    end
    check("abort no output", 128'(quiet), 128'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p;
    build_sbox();
    do_reset();
    run_block("c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0);
    run_block("appb", 128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734, 0);
    run_block("zero", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, 5);
    run_abort(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f);
    run_block("c1 retry", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0);
    do_reset();
    run_block("c1 first", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0);
    run_block("c1 second", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0);
    run_block("appb again", 128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734, 0);
    k = rnd128();
    for (int j = 0; j < 24; j++) begin
      if (j % 3 != 2) k = rnd128();
      p = rnd128();
      run_block($sformatf("rnd%0d", j), aes_enc(p, k), k, p, int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
